load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Core-side initiator for the data memory: accepts one load/store from the execute stage,
//  checks alignment, builds byte mask and lane-replicated store data, and drives the memory
//  request/we_re/load/mask/address/data_in interface. For loads it waits for the memory
//  valid, then extracts and sign/zero-extends the result. Stalls the core while busy.
// PARAMETERS
//  DataWidth      32  memory data width; fixed at 32 for RV32I
//  Address        8   memory word-address width; mem_address = addr[Address+1:2]
//  TimeoutCycles  15  max WAIT cycles before a load is aborted with lsu_err
// PORTS
//  clk            in   1          clock
//  rst            in   1          asynchronous, active-low reset
//  lsu_req        in   1          core request; sampled only when lsu_busy=0
//  lsu_we         in   1          1=store, 0=load
//  lsu_funct3     in   3          RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  lsu_addr       in   32         byte address
//  lsu_wdata      in   32         store data (rs2)
//  lsu_busy       out  1          request in flight; core must stall
//  lsu_done       out  1          one-cycle completion pulse
//  lsu_rdata      out  32         formatted load result; valid with lsu_done on loads
//  lsu_misaligned out  1          with lsu_done: access misaligned, no memory access made
//  lsu_err        out  1          with lsu_done: illegal funct3 or load timeout
//  mem_request    out  1          memory access strobe (one cycle)
//  mem_we_re      out  1          1=write, 0=read
//  mem_load       out  1          high with mem_request on loads
//  mem_mask       out  4          byte enables
//  mem_address    out  Address    word address
//  mem_wdata      out  DataWidth  lane-replicated store data
//  mem_valid      in   1          memory read valid (registered copy of mem_load)
//  mem_rdata      in   DataWidth  memory read word, valid while mem_valid=1
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (lsu_rdata=0, mem_* =0, wait counter=0).
//  FSM: IDLE -> ISSUE on accepted legal aligned request; ISSUE -> WAIT (load) or IDLE (store);
//   WAIT -> IDLE on mem_valid or timeout. lsu_busy = (state != IDLE).
//  Accept edge E0: capture we, funct3, addr, wdata. Misaligned (LW/SW addr[1:0]!=0;
//   LH/LHU/SH addr[0]!=0) or illegal funct3 (load 011/110/111, store >=011): stay IDLE,
//   lsu_done=1 next cycle with lsu_misaligned / lsu_err; misaligned takes priority.
//  ISSUE (one cycle): mem_request=1, mem_we_re=lsu_we, mem_load=!lsu_we; mem_* registered,
//   zero outside ISSUE. Mask: B=4'b0001<<addr[1:0], H=4'b0011<<addr[1:0], W=4'b1111.
//   Store data: SB byte x4, SH half x2, SW as-is. Loads use the same mask.
//  Store latency: lsu_done 2 cycles after E0. Load: mem_valid expected cycle after ISSUE;
//   on edge with mem_valid in WAIT, register lsu_rdata, lsu_done=1 next cycle (3 cycles nominal).
//  Load format: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  Timeout: counter counts WAIT cycles; reaching TimeoutCycles -> IDLE, lsu_done+lsu_err,
//   lsu_rdata=0. mem_valid outside WAIT ignored.
//  lsu_done, lsu_misaligned, lsu_err are single-cycle pulses; lsu_rdata holds until next load.
//  New request accepted in the same cycle lsu_done is high (back-to-back).
//  rst low mid-access: immediate return to IDLE, outputs cleared, no lsu_done.
// STRUCTURE
//  Package rv32i_lsu_pkg: funct3 enum (F3_B/H/W/BU/HU), lsu_state_e {IDLE,ISSUE,WAIT}.
//  Sub-module lsu_align (combinational): misalign check, mask, store replicate, load extract.
// TESTING
//  SW 0xDEADBEEF @0x10 -> mask 1111, address 0x04, wdata 0xDEADBEEF, lsu_done at E0+2.
//  SB 0x000000A5 @0x13, then LB @0x13 -> mask 1000, wdata 0xA5A5A5A5; rdata 0xFFFFFFA5.
//  SH 0x8001 @0x12, LHU @0x12 / LH @0x12 -> 0x00008001 / 0xFFFF8001, done at E0+3.
//  LW @0x02 -> no mem_request, lsu_done+lsu_misaligned at E0+1; funct3=3'b011 load -> lsu_err.
//  Load with mem_valid held low -> lsu_done+lsu_err after 15 WAIT cycles, rdata=0.
//  Back-to-back SW then LW issued on done cycle; rst dropped during WAIT -> all outputs 0.

Source files
------------

// File: rtl/rv32i_lsu_pkg.sv
// Shared types for the RV32I load/store unit: funct3 encodings and FSM states.
package rv32i_lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } lsu_state_e;

  // Access size as encoded in funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Combinational access formatter: alignment/legality check, byte mask,
// store-lane replication and load-result extraction with sign/zero extension.
module lsu_align
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 i_we,
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_addr_lo,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [DataWidth-1:0] i_rdata,
  output logic                 o_misaligned,
  output logic                 o_illegal,
  output logic [3:0]           o_mask,
  output logic [DataWidth-1:0] o_wdata,
  output logic [DataWidth-1:0] o_rdata
);

  logic [DataWidth-1:0] w_shifted;

  // Size-dependent mask, replication and alignment check
  always_comb begin
    o_misaligned = 1'b0;
    o_mask       = 4'b1111;
    o_wdata      = i_wdata;
    case (i_funct3[1:0])
      SZ_B: begin
        o_mask  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_misaligned = i_addr_lo[0];
        o_mask       = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_wdata[15:0]}};
      end
      SZ_W: begin
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: begin
        o_misaligned = 1'b0;
      end
    endcase
  end

  // funct3 legality: stores only B/H/W, loads B/H/W/BU/HU
  always_comb begin
    o_illegal = 1'b0;
    if (i_we) begin
      o_illegal = (i_funct3 > 3'b010);
    end else begin
      case (i_funct3)
        3'b011, 3'b110, 3'b111: o_illegal = 1'b1;
        default:                o_illegal = 1'b0;
      endcase
    end
  end

  // Load extraction: shift the addressed lane down, then extend
  always_comb begin
    w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    case (funct3_e'(i_funct3))
      F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_rdata = {24'd0, w_shifted[7:0]};
      F3_HU:   o_rdata = {16'd0, w_shifted[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access, issues a single-cycle memory
// request, waits for load data (with timeout) and reports completion.
module load_store_unit
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned Address       = 8,
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [2:0]           lsu_funct3,
  input  logic [31:0]          lsu_addr,
  input  logic [31:0]          lsu_wdata,
  output logic                 lsu_busy,
  output logic                 lsu_done,
  output logic [31:0]          lsu_rdata,
  output logic                 lsu_misaligned,
  output logic                 lsu_err,
  output logic                 mem_request,
  output logic                 mem_we_re,
  output logic                 mem_load,
  output logic [3:0]           mem_mask,
  output logic [Address-1:0]   mem_address,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_valid,
  input  logic [DataWidth-1:0] mem_rdata
);

  localparam int unsigned     CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  lsu_state_e           r_state;
  logic                 r_we;
  logic [2:0]           r_funct3;
  logic [1:0]           r_addr_lo;
  logic [CntW-1:0]      r_cnt;
  logic                 r_done;
  logic                 r_mis;
  logic                 r_err;
  logic [31:0]          r_rdata;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic                 r_mem_load;
  logic [3:0]           r_mem_mask;
  logic [Address-1:0]   r_mem_addr;
  logic [DataWidth-1:0] r_mem_wdata;

  logic                 w_sel_we;
  logic [2:0]           w_sel_funct3;
  logic [1:0]           w_sel_addr_lo;
  logic                 w_misaligned;
  logic                 w_illegal;
  logic [3:0]           w_mask;
  logic [DataWidth-1:0] w_wdata;
  logic [DataWidth-1:0] w_rdata;

  // One formatter serves both phases: live request fields while IDLE (check,
  // mask, replicate), captured fields afterwards (load extraction in WAIT).
  always_comb begin
    w_sel_we      = lsu_we;
    w_sel_funct3  = lsu_funct3;
    w_sel_addr_lo = lsu_addr[1:0];
    if (r_state != IDLE) begin
      w_sel_we      = r_we;
      w_sel_funct3  = r_funct3;
      w_sel_addr_lo = r_addr_lo;
    end
  end

  lsu_align #(
    .DataWidth(DataWidth)
  ) u_align (
    .i_we         (w_sel_we),
    .i_funct3     (w_sel_funct3),
    .i_addr_lo    (w_sel_addr_lo),
    .i_wdata      (lsu_wdata),
    .i_rdata      (mem_rdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal),
    .o_mask       (w_mask),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata)
  );

  // FSM with registered memory strobes and completion pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_mis       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_load  <= 1'b0;
      r_mem_mask  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done      <= 1'b0;
      r_mis       <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_load  <= 1'b0;
      r_mem_mask  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      case (r_state)
        IDLE: begin
          if (lsu_req) begin
            r_we      <= lsu_we;
            r_funct3  <= lsu_funct3;
            r_addr_lo <= lsu_addr[1:0];
            if (w_misaligned) begin
              r_done <= 1'b1;
              r_mis  <= 1'b1;
            end else if (w_illegal) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state     <= ISSUE;
              r_mem_req   <= 1'b1;
              r_mem_we    <= lsu_we;
              r_mem_load  <= !lsu_we;
              r_mem_mask  <= w_mask;
              r_mem_addr  <= lsu_addr[Address+1:2];
              r_mem_wdata <= lsu_we ? w_wdata : '0;
            end
          end
        end
        ISSUE: begin
          r_cnt <= '0;
          if (r_we) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_valid) begin
            r_rdata <= w_rdata;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (r_cnt == CntLast) begin
            r_rdata <= '0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lsu_busy       = (r_state != IDLE);
  assign lsu_done       = r_done;
  assign lsu_rdata      = r_rdata;
  assign lsu_misaligned = r_mis;
  assign lsu_err        = r_err;
  assign mem_request    = r_mem_req;
  assign mem_we_re      = r_mem_we;
  assign mem_load       = r_mem_load;
  assign mem_mask       = r_mem_mask;
  assign mem_address    = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model predicts every output on
// every cycle; a byte-addressed model memory is kept apart from the responder's
// word memory so store lanes and load extraction are checked end to end.
module tb_load_store_unit;

  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = '0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_busy, lsu_done, lsu_misaligned, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_request, mem_we_re, mem_load;
  logic [3:0]  mem_mask;
  logic [7:0]  mem_address;
  logic [31:0] mem_wdata;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(
    .DataWidth(32),
    .Address(8),
    .TimeoutCycles(15)
  ) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misaligned(lsu_misaligned), .lsu_err(lsu_err),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_load(mem_load),
    .mem_mask(mem_mask), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle
  bit        exp_busy [MAXC];
  bit        exp_done [MAXC];
  bit        exp_mis  [MAXC];
  bit        exp_err  [MAXC];
  bit [31:0] exp_rdata[MAXC];
  bit        exp_req  [MAXC];
  bit        exp_we   [MAXC];
  bit        exp_load [MAXC];
  bit [3:0]  exp_mask [MAXC];
  bit [7:0]  exp_addr [MAXC];
  bit [31:0] exp_wdata[MAXC];
  bit        exp_nowd [MAXC];

  bit [7:0]  mdl_mem[1024];
  logic [31:0] rmem[256];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("busy",      32'(lsu_busy),       32'(exp_busy[cyc]));
      chk("done",      32'(lsu_done),       32'(exp_done[cyc]));
      chk("misalign",  32'(lsu_misaligned), 32'(exp_mis[cyc]));
      chk("err",       32'(lsu_err),        32'(exp_err[cyc]));
      chk("rdata",     lsu_rdata,           exp_rdata[cyc]);
      chk("mem_req",   32'(mem_request),    32'(exp_req[cyc]));
      chk("mem_we",    32'(mem_we_re),      32'(exp_we[cyc]));
      chk("mem_load",  32'(mem_load),       32'(exp_load[cyc]));
      chk("mem_mask",  32'(mem_mask),       32'(exp_mask[cyc]));
      chk("mem_addr",  32'(mem_address),    32'(exp_addr[cyc]));
      if (!exp_nowd[cyc]) chk("mem_wdata", mem_wdata, exp_wdata[cyc]);
    end
  end

  // Snapshot of the latest memory request and completion for literal checks
  int          req_count = 0;
  int          cap_done_cyc = 0;
  logic [3:0]  cap_mask;
  logic [7:0]  cap_addr;
  logic [31:0] cap_wdata, cap_rdata;
  logic        cap_mis, cap_err;
  always @(negedge clk) begin
    if (mem_request === 1'b1) begin
      req_count++;
      cap_mask  = mem_mask;
      cap_addr  = mem_address;
      cap_wdata = mem_wdata;
    end
    if (lsu_done === 1'b1) begin
      cap_done_cyc = cyc;
      cap_rdata    = lsu_rdata;
      cap_mis      = lsu_misaligned;
      cap_err      = lsu_err;
    end
  end

  // Memory responder: writes on store strobes, answers loads after cur_lat cycles
  // (cur_lat == 0 means never answer)
  int cur_lat = 1;
  initial begin
    bit       pending;
    int       cnt;
    bit [7:0] paddr;
    pending = 1'b0;
    cnt = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      mem_rdata = $urandom;
      if (!rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            mem_valid = 1'b1;
            mem_rdata = rmem[paddr];
            pending   = 1'b0;
          end
        end
        if (mem_request === 1'b1) begin
          if (mem_we_re) begin
            for (int j = 0; j < 4; j++)
              if (mem_mask[j]) rmem[mem_address][8*j +: 8] = mem_wdata[8*j +: 8];
          end else if (cur_lat > 0) begin
            pending = 1'b1;
            cnt     = cur_lat;
            paddr   = mem_address;
          end
        end
      end
    end
  end

  int last_launch = 0;

  // Launch one access at the current negedge, record what every later cycle
  // must look like, and return once the access has completed (+gap cycles).
  task automatic run_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, input int lat, input int gap,
                         input int abort_after);
    int n, e0, d, sz, last;
    bit legal, mis;
    bit [31:0] val, rep;
    bit [3:0] msk;
    bit [9:0] ba;
    n  = cyc;
    e0 = n + 1;
    ba = addr[9:0];
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : (f3[1:0] == 2'b10) ? 4 : 0;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    d = e0;
    if (mis) begin
      exp_done[e0] = 1'b1;
      exp_mis[e0]  = 1'b1;
    end else if (!legal) begin
      exp_done[e0] = 1'b1;
      exp_err[e0]  = 1'b1;
    end else begin
      msk = '0;
      for (int i = 0; i < sz; i++) msk[addr[1:0] + i] = 1'b1;
      for (int j = 0; j < 4; j++) rep[8*j +: 8] = wd[8*(j % sz) +: 8];
      exp_busy[e0] = 1'b1;
      exp_req[e0]  = 1'b1;
      exp_we[e0]   = we;
      exp_load[e0] = !we;
      exp_mask[e0] = msk;
      exp_addr[e0] = addr[9:2];
      exp_wdata[e0] = rep;
      exp_nowd[e0]  = !we;
      if (we) begin
        for (int i = 0; i < sz; i++) mdl_mem[ba + 10'(i)] = wd[8*i +: 8];
        d = e0 + 1;
        exp_done[d] = 1'b1;
      end else begin
        val = '0;
        for (int i = 0; i < sz; i++) val[8*i +: 8] = mdl_mem[ba + 10'(i)];
        if (sz == 1) val = f3[2] ? {24'd0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
        if (sz == 2) val = f3[2] ? {16'd0, val[15:0]} : {{16{val[15]}}, val[15:0]};
        last = (lat >= 1 && lat <= 15) ? lat : 15;
        for (int c = e0 + 1; c <= e0 + last; c++) exp_busy[c] = 1'b1;
        d = e0 + last + 1;
        exp_done[d] = 1'b1;
        if (lat < 1 || lat > 15) begin
          exp_err[d] = 1'b1;
          val = '0;
        end
        for (int c = d; c < MAXC; c++) exp_rdata[c] = val;
        if (lat > 16) gap += lat - 16;
      end
    end
    cur_lat     = lat;
    last_launch = n;
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    @(negedge clk);
    lsu_req = 1'b0;
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      #1 rst = 1'b0;
      for (int c = cyc + 1; c < MAXC; c++) begin
        exp_busy[c] = 0; exp_done[c] = 0; exp_mis[c] = 0; exp_err[c] = 0;
        exp_rdata[c] = 0; exp_req[c] = 0; exp_we[c] = 0; exp_load[c] = 0;
        exp_mask[c] = 0; exp_addr[c] = 0; exp_wdata[c] = 0; exp_nowd[c] = 0;
      end
      #1;
      chk("rst_async_busy",  32'(lsu_busy), 32'd0);
      chk("rst_async_rdata", lsu_rdata,     32'd0);
      chk("rst_async_done",  32'(lsu_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
    end else begin
      while (cyc < d) @(negedge clk);
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    #(MAXC * 10 + 5000);
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rq;
    int t, r, lat;
    bit we;
    bit [2:0] f3;
    bit [31:0] addr;
    for (int i = 0; i < 256; i++) begin
      rmem[i] = $urandom;
      for (int j = 0; j < 4; j++) mdl_mem[4*i + j] = rmem[i][8*j +: 8];
    end
    repeat (3) @(negedge clk);
    chk("reset_busy",  32'(lsu_busy),    32'd0);
    chk("reset_rdata", lsu_rdata,        32'd0);
    chk("reset_req",   32'(mem_request), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed accesses with hand-computed results
    run_txn(1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 1, 0);
    chk("sw_mask",  32'(cap_mask), 32'h0000000F);
    chk("sw_addr",  32'(cap_addr), 32'h00000004);
    chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw_lat",   32'(cap_done_cyc - last_launch), 32'd2);

    run_txn(1, 3'b000, 32'h13, 32'h000000A5, 1, 1, 0);
    chk("sb_mask",  32'(cap_mask), 32'h00000008);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    run_txn(0, 3'b000, 32'h13, 32'h0, 1, 1, 0);
    chk("lb_rdata", cap_rdata, 32'hFFFFFFA5);
    chk("lb_lat",   32'(cap_done_cyc - last_launch), 32'd3);

    run_txn(1, 3'b001, 32'h12, 32'h00008001, 1, 1, 0);
    chk("sh_mask",  32'(cap_mask), 32'h0000000C);
    chk("sh_wdata", cap_wdata, 32'h80018001);
    run_txn(0, 3'b101, 32'h12, 32'h0, 1, 1, 0);
    chk("lhu_rdata", cap_rdata, 32'h00008001);
    run_txn(0, 3'b001, 32'h12, 32'h0, 1, 1, 0);
    chk("lh_rdata",  cap_rdata, 32'hFFFF8001);
    chk("lh_lat",    32'(cap_done_cyc - last_launch), 32'd3);
    run_txn(0, 3'b100, 32'h11, 32'h0, 1, 1, 0);
    chk("lbu_rdata", cap_rdata, 32'h000000BE);

    rq = req_count;
    run_txn(0, 3'b010, 32'h02, 32'h0, 1, 1, 0);
    chk("lw_mis_flag", 32'(cap_mis), 32'd1);
    chk("lw_mis_lat",  32'(cap_done_cyc - last_launch), 32'd1);
    chk("lw_mis_noreq", 32'(req_count - rq), 32'd0);
    run_txn(0, 3'b011, 32'h10, 32'h0, 1, 1, 0);
    chk("ill_err", 32'(cap_err), 32'd1);
    chk("ill_mis", 32'(cap_mis), 32'd0);

    run_txn(0, 3'b010, 32'h10, 32'h0, 15, 1, 0);
    chk("lw_lat15_rdata", cap_rdata, 32'h8001BEEF);
    chk("lw_lat15_lat",   32'(cap_done_cyc - last_launch), 32'd17);
    run_txn(0, 3'b010, 32'h10, 32'h0, 0, 1, 0);
    chk("tmo_err",   32'(cap_err), 32'd1);
    chk("tmo_rdata", cap_rdata, 32'd0);
    chk("tmo_lat",   32'(cap_done_cyc - last_launch), 32'd17);
    run_txn(0, 3'b010, 32'h10, 32'h0, 20, 1, 0);

    // Back-to-back: load launched on the store's done cycle
    run_txn(1, 3'b010, 32'h40, 32'h12345678, 1, 0, 0);
    run_txn(0, 3'b010, 32'h40, 32'h0, 1, 1, 0);
    chk("b2b_rdata", cap_rdata, 32'h12345678);
    chk("b2b_lat",   32'(cap_done_cyc - last_launch), 32'd3);

    // Reset dropped while the load is in WAIT
    run_txn(0, 3'b010, 32'h40, 32'h0, 0, 0, 5);
    @(negedge clk);

    // Randomized accesses
    t = 0;
    while (t < 200 && cyc < MAXC - 200) begin
      we   = 1'($urandom_range(0, 1));
      addr = $urandom;
      r    = $urandom_range(0, 9);
      if (r == 0) begin
        f3 = we ? 3'($urandom_range(3, 7)) : ((r % 2 == 0) ? 3'b011 : 3'($urandom_range(6, 7)));
        addr[1:0] = 2'b00;
      end else begin
        case ($urandom_range(0, we ? 2 : 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        if ($urandom_range(0, 3) != 0) begin
          if (f3[1:0] == 2'b01) addr[0] = 1'b0;
          if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
        end
      end
      r = $urandom_range(0, 19);
      if (r < 14)       lat = 1 + (r % 3);
      else if (r < 16)  lat = 15;
      else if (r == 16) lat = 16;
      else if (r == 17) lat = 20;
      else              lat = 0;
      run_txn(we, f3, addr, $urandom, lat, $urandom_range(0, 2), 0);
      t++;
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
